stack_arbiter: RTL and testbench

Controller that shares one `Stack` datapath instance between `N_REQ` requesters. Each requester issues push/pop transactions over a valid/ready handshake. The controller arbitrates round-robin, tracks occupancy, and blocks illegal operations: pushes on full and pops on empty are rejected with an error response and never reach the datapath. It sits between the requesting units and the stack datapath and is the only driver of the datapath's `push`, `pop`, `rst` and `data_IN`.

---
 rtl/stack_arbiter_if.sv | 24 ++
 rtl/stack_arbiter.sv | 119 +++++++++++
 tb/tb_stack_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_arbiter_if.sv
// Requester-side request/response bundle for stack_arbiter.
// Valid/ready: a request transfers on the posedge where req_valid[i] & req_ready[i] are both high; resp_valid is a one-cycle completion pulse.
interface stack_arbiter_if #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 8
);
    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ-1:0]                 req_push;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]                 req_ready;
    logic [N_REQ-1:0]                 resp_valid;
    logic                             resp_err;
    logic [DATA_WIDTH-1:0]            resp_data;

    modport master (
        output req_valid, req_push, req_data,
        input  req_ready, resp_valid, resp_err, resp_data
    );

    modport slave (
        input  req_valid, req_push, req_data,
        output req_ready, resp_valid, resp_err, resp_data
    );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin controller sharing one stack datapath between N_REQ requesters.
// Tracks occupancy and rejects push-on-full / pop-on-empty before they reach the datapath.
module stack_arbiter #(
    parameter int LENGTH     = 8,
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    stack_arbiter_if.slave               bus,
    input  logic                         flush,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic                         stk_rst,
    output logic [DATA_WIDTH-1:0]        stk_data,
    input  logic [DATA_WIDTH-1:0]        stk_q,
    output logic [$clog2(LENGTH+1)-1:0]  depth,
    output logic                         full,
    output logic                         empty,
    output logic [1:0]                   fsm_state
);
    localparam int DW = $clog2(LENGTH + 1);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] CLR   = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]            state;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         win_q;
    logic                  op_push_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  grant_found;
    logic [IW-1:0]         grant_idx;
    int                    cand;
    logic                  handshake;
    logic                  issue_push;
    logic                  issue_pop;

    // Walk offsets from farthest to nearest so the nearest valid requester after ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = (int'(ptr) + off) % N_REQ;
            if (bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
    end

    assign handshake     = (state == IDLE) && !flush && grant_found;
    assign bus.req_ready = handshake ? (N_REQ'(1) << grant_idx) : '0;

    assign full       = (depth == DW'(LENGTH));
    assign empty      = (depth == '0);
    assign issue_push = (state == ISSUE) &&  op_push_q && !full;
    assign issue_pop  = (state == ISSUE) && !op_push_q && !empty;

    assign stk_rst  = (state == CLR);
    assign stk_push = issue_push;
    assign stk_pop  = issue_pop;
    assign stk_data = issue_push ? data_q : '0;

    assign bus.resp_valid = (state == RESP) ? (N_REQ'(1) << win_q) : '0;
    assign bus.resp_err   = (state == RESP) && err_q;
    assign bus.resp_data  = (state == RESP) ? rdata_q : '0;
    assign fsm_state      = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CLR;
            depth     <= '0;
            ptr       <= IW'(N_REQ - 1);
            win_q     <= '0;
            op_push_q <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state)
                CLR: begin
                    depth <= '0;
                    state <= IDLE;
                end
                IDLE: begin
                    if (flush) begin
                        state <= CLR;
                    end else if (handshake) begin
                        win_q     <= grant_idx;
                        ptr       <= grant_idx;
                        op_push_q <= bus.req_push[grant_idx];
                        data_q    <= bus.req_data[grant_idx];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_push) depth <= depth + DW'(1);
                    else if (issue_pop) depth <= depth - DW'(1);
                    err_q   <= !(issue_push || issue_pop);
                    // stk_q still shows the pre-shift top on this edge.
                    rdata_q <= issue_pop ? stk_q : '0;
                    state   <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= CLR;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter: vector table of whole transactions plus hand sequences
// for reset release, flush and reset during ISSUE; a small stack model stands in for the datapath.
module tb_stack_arbiter;
    localparam int LENGTH = 8;
    localparam int DW     = 8;
    localparam int N      = 2;

    localparam logic [1:0] S_CLR   = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stk_push, stk_pop, stk_rst;
    logic [7:0]  stk_data, stk_q;
    logic [3:0]  depth;
    logic        full, empty;
    logic [1:0]  fsm_state;

    stack_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

    stack_arbiter #(.LENGTH(LENGTH), .DATA_WIDTH(DW), .N_REQ(N)) dut (
        .clk(clk), .rst(rst), .bus(bus), .flush(flush),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_rst(stk_rst),
        .stk_data(stk_data), .stk_q(stk_q), .depth(depth),
        .full(full), .empty(empty), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // datapath stand-in
    logic [7:0] mem [0:LENGTH-1];
    int sp;
    assign stk_q = (sp > 0) ? mem[sp-1] : 8'h00;
    always @(posedge clk) begin
        if (stk_rst) sp <= 0;
        else if (stk_push && sp < LENGTH) begin
            mem[sp] <= stk_data;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) sp <= sp - 1;
    end

    // scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [1:0] push;
        logic [7:0] d0;
        logic [7:0] d1;
        int         win;
        logic       err;
        logic [7:0] rdata;
        int         dep;
    } vec_t;

    vec_t vecs[$];

    // driver: one complete transaction, checked phase by phase
    task automatic run_txn(input string name, input bit sync, input vec_t v);
        int         waited;
        logic       push_op;
        logic       exp_spush, exp_spop;
        logic [7:0] exp_sdata;
        logic [7:0] exp_word;
        if (sync) @(negedge clk);
        bus.req_valid   = v.valid;
        bus.req_push    = v.push;
        bus.req_data[0] = v.d0;
        bus.req_data[1] = v.d1;
        #1;
        waited = 0;
        while (bus.req_ready == '0 && waited < 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (bus.req_ready == '0) begin
            check({name, ".grant_timeout"}, 32'(bus.req_ready), 32'(1 << v.win));
            bus.req_valid = '0;
            return;
        end
        check({name, ".grant_wait"}, 32'(waited), 32'd0);
        check({name, ".ready"}, 32'(bus.req_ready), 32'(1 << v.win));
        push_op   = v.push[v.win];
        exp_spush = push_op && !v.err;
        exp_spop  = !push_op && !v.err;
        exp_sdata = exp_spush ? ((v.win == 1) ? v.d1 : v.d0) : 8'h00;
        exp_q.push_back(v.rdata);

        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check({name, ".stk_push"}, 32'(stk_push), 32'(exp_spush));
        check({name, ".stk_pop"}, 32'(stk_pop), 32'(exp_spop));
        check({name, ".stk_data"}, 32'(stk_data), 32'(exp_sdata));
        check({name, ".ready_issue"}, 32'(bus.req_ready), 32'd0);

        @(negedge clk);
        #1;
        exp_word = exp_q.pop_front();
        check({name, ".resp_valid"}, 32'(bus.resp_valid), 32'(1 << v.win));
        check({name, ".resp_err"}, 32'(bus.resp_err), 32'(v.err));
        check({name, ".resp_data"}, 32'(bus.resp_data), 32'(exp_word));
        check({name, ".depth"}, 32'(depth), 32'(v.dep));
        check({name, ".full"}, 32'(full), 32'(v.dep == LENGTH));
        check({name, ".empty"}, 32'(empty), 32'(v.dep == 0));
    endtask

    function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] push,
                                input logic [7:0] d0, input logic [7:0] d1, input int win,
                                input logic err, input logic [7:0] rdata, input int dep);
        vec_t v;
        v.valid = valid; v.push = push; v.d0 = d0; v.d1 = d1;
        v.win = win; v.err = err; v.rdata = rdata; v.dep = dep;
        return v;
    endfunction

    initial begin
        vec_t v;
        // stack holds A5 from the first-access sequence; pointer then sits at 0
        vecs.push_back(mk(2'b01, 2'b00, 8'h00, 8'h00, 0, 1'b0, 8'hA5, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(2'b10, 2'b10, 8'h00, 8'(i), 1, 1'b0, 8'h00, i));
        vecs.push_back(mk(2'b10, 2'b10, 8'h00, 8'h09, 1, 1'b1, 8'h00, 8));
        for (int i = 8; i >= 1; i--)
            vecs.push_back(mk(2'b10, 2'b00, 8'h00, 8'h00, 1, 1'b0, 8'(i), i - 1));
        vecs.push_back(mk(2'b10, 2'b00, 8'h00, 8'h00, 1, 1'b1, 8'h00, 0));
        vecs.push_back(mk(2'b01, 2'b01, 8'h11, 8'h00, 0, 1'b0, 8'h00, 1));
        vecs.push_back(mk(2'b10, 2'b00, 8'h00, 8'h00, 1, 1'b0, 8'h11, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(2'b11, 2'b11, 8'h20 + 8'(k), 8'h30 + 8'(k), k % 2, 1'b0, 8'h00, k + 1));
        vecs.push_back(mk(2'b10, 2'b10, 8'h00, 8'h35, 1, 1'b0, 8'h00, 5));
        vecs.push_back(mk(2'b10, 2'b00, 8'h00, 8'h00, 1, 1'b0, 8'h35, 4));
        vecs.push_back(mk(2'b10, 2'b10, 8'h00, 8'h36, 1, 1'b0, 8'h00, 5));

        rst           = 1'b0;
        flush         = 1'b0;
        bus.req_valid = '0;
        bus.req_push  = '0;
        bus.req_data  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst.state", 32'(fsm_state), 32'(S_CLR));
        check("rst.depth", 32'(depth), 32'd0);
        check("rst.empty", 32'(empty), 32'd1);
        check("rst.full", 32'(full), 32'd0);
        check("rst.ready", 32'(bus.req_ready), 32'd0);
        check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst.resp_err", 32'(bus.resp_err), 32'd0);
        check("rst.resp_data", 32'(bus.resp_data), 32'd0);
        check("rst.stk_strobes", 32'({stk_push, stk_pop}), 32'd0);
        check("rst.stk_data", 32'(stk_data), 32'd0);
        check("rst.stk_rst", 32'(stk_rst), 32'd1);

        // first access after release
        @(negedge clk);
        rst             = 1'b1;
        bus.req_valid   = 2'b01;
        bus.req_push    = 2'b01;
        bus.req_data[0] = 8'hA5;
        #1;
        check("first.clr_stk_rst", 32'(stk_rst), 32'd1);
        check("first.clr_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("first.stk_rst_low", 32'(stk_rst), 32'd0);
        check("first.ready", 32'(bus.req_ready), 32'b01);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("first.stk_push", 32'(stk_push), 32'd1);
        check("first.stk_data", 32'(stk_data), 32'hA5);
        @(negedge clk);
        #1;
        check("first.resp_valid", 32'(bus.resp_valid), 32'b01);
        check("first.resp_err", 32'(bus.resp_err), 32'd0);
        check("first.resp_data", 32'(bus.resp_data), 32'd0);
        check("first.depth", 32'(depth), 32'd1);

        foreach (vecs[i]) run_txn($sformatf("vec%0d", i), 1'b1, vecs[i]);

        // flush with a pending request at depth 5
        @(negedge clk);
        flush           = 1'b1;
        bus.req_valid   = 2'b01;
        bus.req_push    = 2'b01;
        bus.req_data[0] = 8'h77;
        #1;
        check("flush.no_grant", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush.clr_state", 32'(fsm_state), 32'(S_CLR));
        check("flush.stk_rst", 32'(stk_rst), 32'd1);
        check("flush.clr_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("flush.depth", 32'(depth), 32'd0);
        run_txn("flush.txn", 1'b0, mk(2'b01, 2'b01, 8'h77, 8'h00, 0, 1'b0, 8'h00, 1));

        // reset while a push is in ISSUE
        @(negedge clk);
        bus.req_valid   = 2'b10;
        bus.req_push    = 2'b10;
        bus.req_data[1] = 8'h88;
        #1;
        check("midrst.ready", 32'(bus.req_ready), 32'b10);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("midrst.issue_push", 32'(stk_push), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst.push_drop", 32'(stk_push), 32'd0);
        check("midrst.stk_rst", 32'(stk_rst), 32'd1);
        check("midrst.depth_async", 32'(depth), 32'd0);
        @(negedge clk);
        #1;
        check("midrst.no_resp", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.no_resp_clr", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("midrst.idle", 32'(fsm_state), 32'(S_IDLE));
        check("midrst.depth", 32'(depth), 32'd0);
        run_txn("midrst.pop", 1'b1, mk(2'b01, 2'b00, 8'h00, 8'h00, 0, 1'b1, 8'h00, 0));

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // strobes must never coincide and only appear in ISSUE
    always @(negedge clk) begin
        if (rst && (stk_push || stk_pop)) begin
            check("strobe_exclusive", 32'(stk_push && stk_pop), 32'd0);
            check("strobe_in_issue", 32'(fsm_state), 32'(S_ISSUE));
        end
    end
endmodule
